// File: rtl/inst_mem_sram_ctrl.sv
// inst_mem_sram_ctrl: instruction-fetch controller on a shared asynchronous SRAM.
// The IF stage and the MEM stage share one SRAM port. A data access always
// wins arbitration over a fetch. While a fetch is outstanding, IF sees NOP_WORD
// on if_data and if_stall high. Every output comes straight from a flop, so the
// SRAM pins and the pipeline-facing signals are glitch-free.
//
// Handshake semantics:
//   IF side  : if_req is a level. It is sampled only when the controller is
//              IDLE. if_valid is a one-cycle pulse, and if_data carries the
//              fetched word in that cycle only. In every other cycle if_data
//              is NOP_WORD, which gives the pipeline its bubble.
//   MEM side : mem_req is a level. The requester holds it until mem_done.
//              mem_we, mem_addr and mem_wdata are sampled in the same cycle
//              as the accepting edge. mem_done is a one-cycle pulse. For a
//              read, mem_rdata is valid in the mem_done cycle and holds its
//              value afterwards. Once an access has been accepted it always
//              completes, even if mem_req drops.
module inst_mem_sram_ctrl #(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 18,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [DATA_W-1:0] NOP_WORD    = 16'h0800
) (
    input  logic              clk,
    input  logic              rst,
    // instruction fetch port
    input  logic              if_req,
    input  logic [15:0]       if_addr,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_data,
    output logic              if_stall,
    // data access port
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [15:0]       mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    // SRAM pins
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    input  logic [DATA_W-1:0] sram_din,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    // FSM state, exposed for observation
    output logic [2:0]        dbg_state
);

    // The wait counter is 4 bits wide, so at most 15 extra wait cycles fit.
    // CPU addresses are zero-extended onto the SRAM bus and can never be narrowed.
    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
            $error("inst_mem_sram_ctrl: WAIT_CYCLES must be in 0..15");
        end
        if (ADDR_W < 16) begin : g_bad_addr_w
            $error("inst_mem_sram_ctrl: ADDR_W must be at least 16");
        end
    endgenerate

    // Counter value seen on the final cycle of an access phase.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_IF_RD    = 3'd1,
        ST_MEM_RD   = 3'd2,
        ST_MEM_WR   = 3'd3,
        ST_WR_RECOV = 3'd4
    } state_e;

    state_e            state_q,     state_d;
    logic [3:0]        cnt_q,       cnt_d;
    logic              if_valid_q,  if_valid_d;
    logic [DATA_W-1:0] if_data_q,   if_data_d;
    logic              if_stall_q,  if_stall_d;
    logic              mem_done_q,  mem_done_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0] sram_dout_q, sram_dout_d;
    logic              dq_oe_q,     dq_oe_d;
    logic              ce_n_q,      ce_n_d;
    logic              oe_n_q,      oe_n_d;
    logic              we_n_q,      we_n_d;

    logic              phase_last;
    logic [ADDR_W-1:0] if_addr_ext;
    logic [ADDR_W-1:0] mem_addr_ext;

    // This is the final cycle of the current access phase once the counter reaches WAIT_LAST.
    always_comb begin
        phase_last   = (cnt_q == WAIT_LAST);
        if_addr_ext  = ADDR_W'(if_addr);
        mem_addr_ext = ADDR_W'(mem_addr);
    end

    // Arbitration, access sequencing and next values of all registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        if_valid_d  = 1'b0;
        if_data_d   = NOP_WORD;
        mem_done_d  = 1'b0;
        mem_rdata_d = mem_rdata_q;
        sram_addr_d = sram_addr_q;
        sram_dout_d = sram_dout_q;

        case (state_q)
            ST_IDLE: begin
                // A data access wins a tie. The MEM stage is itself stalled
                // behind IF, so the fetch cannot be starved.
                if (mem_req) begin
                    state_d     = mem_we ? ST_MEM_WR : ST_MEM_RD;
                    sram_addr_d = mem_addr_ext;
                    cnt_d       = 4'd0;
                    if (mem_we) begin
                        sram_dout_d = mem_wdata;
                    end
                end else if (if_req) begin
                    state_d     = ST_IF_RD;
                    sram_addr_d = if_addr_ext;
                    cnt_d       = 4'd0;
                end
            end

            ST_IF_RD: begin
                if (phase_last) begin
                    if_data_d  = sram_din;
                    if_valid_d = 1'b1;
                    cnt_d      = 4'd0;
                    state_d    = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_MEM_RD: begin
                if (phase_last) begin
                    mem_rdata_d = sram_din;
                    mem_done_d  = 1'b1;
                    cnt_d       = 4'd0;
                    state_d     = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_MEM_WR: begin
                if (phase_last) begin
                    cnt_d   = 4'd0;
                    state_d = ST_WR_RECOV;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_WR_RECOV: begin
                // we_n has already risen and the data stays driven for hold time.
                // The write is reported complete as the controller returns to IDLE.
                mem_done_d = 1'b1;
                state_d    = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // The strobes follow the state being entered, so they are valid
        // from the first cycle of each phase.
        ce_n_d  = (state_d == ST_IDLE);
        oe_n_d  = !((state_d == ST_IF_RD) || (state_d == ST_MEM_RD));
        we_n_d  = (state_d != ST_MEM_WR);
        dq_oe_d = (state_d == ST_MEM_WR) || (state_d == ST_WR_RECOV);

        // IF may advance only when the bus is free or a fetch has just completed.
        // A MEM access that is about to win the bus also holds IF.
        if_stall_d = (state_d != ST_IDLE) || (mem_req && if_req);
    end

    // State and output registers. An asynchronous reset abandons any access that is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            if_valid_q  <= 1'b0;
            if_data_q   <= NOP_WORD;
            if_stall_q  <= 1'b0;
            mem_done_q  <= 1'b0;
            mem_rdata_q <= '0;
            sram_addr_q <= '0;
            sram_dout_q <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if_valid_q  <= if_valid_d;
            if_data_q   <= if_data_d;
            if_stall_q  <= if_stall_d;
            mem_done_q  <= mem_done_d;
            mem_rdata_q <= mem_rdata_d;
            sram_addr_q <= sram_addr_d;
            sram_dout_q <= sram_dout_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
        end
    end

    // Drive the outputs directly from the flops.
    always_comb begin
        if_valid   = if_valid_q;
        if_data    = if_data_q;
        if_stall   = if_stall_q;
        mem_done   = mem_done_q;
        mem_rdata  = mem_rdata_q;
        sram_addr  = sram_addr_q;
        sram_dout  = sram_dout_q;
        sram_dq_oe = dq_oe_q;
        sram_ce_n  = ce_n_q;
        sram_oe_n  = oe_n_q;
        sram_we_n  = we_n_q;
        dbg_state  = state_q;
    end

endmodule

// File: tb/tb_inst_mem_sram_ctrl.sv
// tb_inst_mem_sram_ctrl: self-checking bench for inst_mem_sram_ctrl.
// The main DUT uses WAIT_CYCLES=1. Two extra instances, with WAIT_CYCLES=0 and
// WAIT_CYCLES=3, share its inputs and are used to check how latency scales.
// The SRAM model is an asynchronous array. A write is captured on the rising
// edge of we_n.
module tb_inst_mem_sram_ctrl;

  localparam logic [15:0] NOP        = 16'h0800;
  localparam logic [2:0]  S_IDLE     = 3'd0;
  localparam logic [2:0]  S_IF_RD    = 3'd1;
  localparam logic [2:0]  S_MEM_RD   = 3'd2;
  localparam logic [2:0]  S_MEM_WR   = 3'd3;
  localparam logic [2:0]  S_WR_RECOV = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- shared inputs ----------------
  logic        if_req    = 1'b0;
  logic [15:0] if_addr   = '0;
  logic        mem_req   = 1'b0;
  logic        mem_we    = 1'b0;
  logic [15:0] mem_addr  = '0;
  logic [15:0] mem_wdata = '0;

  // ---------------- main DUT (W=1) ----------------
  logic        if_valid, if_stall, mem_done, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [15:0] if_data, mem_rdata, sram_dout, sram_din;
  logic [17:0] sram_addr;
  logic [2:0]  dbg_state;

  // ---------------- W=0 and W=3 instances ----------------
  logic        w0_if_valid, w0_if_stall, w0_mem_done, w0_dq_oe, w0_ce_n, w0_oe_n, w0_we_n;
  logic [15:0] w0_if_data, w0_mem_rdata, w0_dout, w0_din;
  logic [17:0] w0_addr;
  logic [2:0]  w0_state;
  logic        w3_if_valid, w3_if_stall, w3_mem_done, w3_dq_oe, w3_ce_n, w3_oe_n, w3_we_n;
  logic [15:0] w3_if_data, w3_mem_rdata, w3_dout, w3_din;
  logic [17:0] w3_addr;
  logic [2:0]  w3_state;

  // ---------------- SRAM model ----------------
  logic [15:0] sram_mem [0:65535];

  function automatic logic [15:0] pat(input logic [15:0] a);
    logic [15:0] p;
    p = (a * 16'h1111) ^ 16'h5a5a;
    if (a == 16'h0001) p = 16'h690a;
    return p;
  endfunction

  initial begin
    for (int i = 0; i < 65536; i++) sram_mem[i] = pat(16'(i));
  end

  assign sram_din = (!sram_ce_n && !sram_oe_n) ? sram_mem[sram_addr[15:0]] : 16'hdead;
  assign w0_din   = (!w0_ce_n && !w0_oe_n) ? sram_mem[w0_addr[15:0]] : 16'hdead;
  assign w3_din   = (!w3_ce_n && !w3_oe_n) ? sram_mem[w3_addr[15:0]] : 16'hdead;

  always @(posedge sram_we_n) begin
    if (!sram_ce_n && sram_dq_oe) sram_mem[sram_addr[15:0]] = sram_dout;
  end

  inst_mem_sram_ctrl #(.WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_data(if_data), .if_stall(if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din), .sram_dq_oe(sram_dq_oe),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .dbg_state(dbg_state)
  );

  inst_mem_sram_ctrl #(.WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(w0_if_valid), .if_data(w0_if_data), .if_stall(w0_if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(w0_mem_rdata), .mem_done(w0_mem_done),
    .sram_addr(w0_addr), .sram_dout(w0_dout), .sram_din(w0_din), .sram_dq_oe(w0_dq_oe),
    .sram_ce_n(w0_ce_n), .sram_oe_n(w0_oe_n), .sram_we_n(w0_we_n), .dbg_state(w0_state)
  );

  inst_mem_sram_ctrl #(.WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_valid(w3_if_valid), .if_data(w3_if_data), .if_stall(w3_if_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(w3_mem_rdata), .mem_done(w3_mem_done),
    .sram_addr(w3_addr), .sram_dout(w3_dout), .sram_din(w3_din), .sram_dq_oe(w3_dq_oe),
    .sram_ce_n(w3_ce_n), .sram_oe_n(w3_oe_n), .sram_we_n(w3_we_n), .dbg_state(w3_state)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [15:0] mem_exp_q[$];
  logic [15:0] exp_v;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic tick();
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int valids;
    #2 rst = 1'b0;
    #1;
    n_checks++; if (if_valid !== 1'b0) begin n_fail++; $display("FAIL rst_if_valid got=%b exp=0", if_valid); end
    n_checks++; if (if_data !== NOP) begin n_fail++; $display("FAIL rst_if_data got=%h exp=%h", if_data, NOP); end
    n_checks++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL rst_if_stall got=%b exp=0", if_stall); end
    n_checks++; if (mem_done !== 1'b0) begin n_fail++; $display("FAIL rst_mem_done got=%b exp=0", mem_done); end
    n_checks++; if (mem_rdata !== 16'h0) begin n_fail++; $display("FAIL rst_mem_rdata got=%h exp=0", mem_rdata); end
    n_checks++; if (sram_addr !== 18'h0) begin n_fail++; $display("FAIL rst_sram_addr got=%h exp=0", sram_addr); end
    n_checks++; if (sram_dq_oe !== 1'b0) begin n_fail++; $display("FAIL rst_dq_oe got=%b exp=0", sram_dq_oe); end
    n_checks++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin n_fail++; $display("FAIL rst_strobes got=%b exp=111", {sram_ce_n, sram_oe_n, sram_we_n}); end
    n_checks++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL rst_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    tick();
    rst = 1'b1;
    tick();
    // Reset in the middle of a fetch: the outputs clear immediately and nothing is retried.
    if_req = 1'b1; if_addr = 16'h0004;
    tick();
    if_req = 1'b0;
    n_checks++; if (sram_ce_n !== 1'b0 || dbg_state !== S_IF_RD) begin n_fail++; $display("FAIL midrst_in_fetch got=ce_n:%b st:%0d exp=ce_n:0 st:%0d", sram_ce_n, dbg_state, S_IF_RD); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if ({sram_ce_n, sram_oe_n, sram_we_n} !== 3'b111) begin n_fail++; $display("FAIL midrst_strobes got=%b exp=111", {sram_ce_n, sram_oe_n, sram_we_n}); end
    n_checks++; if (if_data !== NOP || if_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_if got=data:%h v:%b exp=data:%h v:0", if_data, if_valid, NOP); end
    n_checks++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL midrst_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    tick();
    rst = 1'b1;
    valids = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (if_valid) valids++;
    end
    n_checks++; if (valids !== 0) begin n_fail++; $display("FAIL midrst_no_retry got=%0d exp=0", valids); end
  endtask

  task automatic test_single_fetch();
    int lat;
    lat = -1;
    if_req = 1'b1; if_addr = 16'h0001;
    exp_q.push_back(16'h690a);
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 1) begin
        if_req = 1'b0;
        n_checks++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL fetch_stall_pending got=%b exp=1", if_stall); end
      end
      if (if_valid) begin lat = t; break; end
    end
    exp_v = exp_q.pop_front();
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL fetch_latency got=%0d exp=3", lat); end
    n_checks++; if (if_data !== exp_v) begin n_fail++; $display("FAIL fetch_data got=%h exp=%h", if_data, exp_v); end
    n_checks++; if (if_stall !== 1'b0) begin n_fail++; $display("FAIL fetch_stall_release got=%b exp=0", if_stall); end
    tick();
    n_checks++; if (if_valid !== 1'b0 || if_data !== NOP) begin n_fail++; $display("FAIL fetch_bubble got=v:%b d:%h exp=v:0 d:%h", if_valid, if_data, NOP); end
  endtask

  task automatic test_back_to_back();
    int nxt, last, got;
    nxt = 1; last = 0; got = 0;
    if_req = 1'b1; if_addr = 16'h0001;
    exp_q.push_back(pat(16'h0001));
    for (int t = 1; t <= 60; t++) begin
      tick();
      if (if_valid) begin
        exp_v = exp_q.pop_front();
        n_checks++; if (t - last !== 3) begin n_fail++; $display("FAIL stream_interval got=%0d exp=3 word=%0d", t - last, got); end
        n_checks++; if (if_data !== exp_v) begin n_fail++; $display("FAIL stream_data got=%h exp=%h word=%0d", if_data, exp_v, got); end
        got++;
        last = t;
        if (nxt < 9) begin
          nxt++;
          if_addr = 16'(nxt);
          exp_q.push_back(pat(16'(nxt)));
        end else begin
          if_req = 1'b0;
        end
      end
      if (got == 9) break;
    end
    n_checks++; if (got !== 9) begin n_fail++; $display("FAIL stream_count got=%0d exp=9", got); end
    tick();
  endtask

  task automatic test_priority();
    int done_t, valid_t, we_low, recov;
    done_t = -1; valid_t = -1; we_low = 0; recov = 0;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h8000; mem_wdata = 16'hbeef;
    if_req = 1'b1; if_addr = 16'h0002;
    exp_q.push_back(pat(16'h0002));
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (t == 1) begin
        n_checks++; if (dbg_state !== S_MEM_WR || sram_addr !== 18'h08000 || sram_dout !== 16'hbeef || sram_dq_oe !== 1'b1)
          begin n_fail++; $display("FAIL prio_write_first got=st:%0d a:%h d:%h oe:%b exp=st:%0d a:08000 d:beef oe:1", dbg_state, sram_addr, sram_dout, sram_dq_oe, S_MEM_WR); end
        n_checks++; if (if_stall !== 1'b1) begin n_fail++; $display("FAIL prio_if_stall got=%b exp=1", if_stall); end
      end
      if (!sram_we_n) we_low++;
      if (dbg_state == S_WR_RECOV) begin
        recov++;
        n_checks++; if (sram_dq_oe !== 1'b1 || sram_we_n !== 1'b1) begin n_fail++; $display("FAIL recov_hold got=oe:%b we_n:%b exp=oe:1 we_n:1", sram_dq_oe, sram_we_n); end
      end
      if (mem_done && done_t < 0) begin done_t = t; mem_req = 1'b0; mem_we = 1'b0; end
      if (if_valid) begin
        valid_t = t;
        if_req = 1'b0;
        exp_v = exp_q.pop_front();
        n_checks++; if (if_data !== exp_v) begin n_fail++; $display("FAIL prio_fetch_data got=%h exp=%h", if_data, exp_v); end
        break;
      end
    end
    n_checks++; if (done_t !== 4) begin n_fail++; $display("FAIL prio_done_cycle got=%0d exp=4", done_t); end
    n_checks++; if (valid_t !== 7) begin n_fail++; $display("FAIL prio_fetch_cycle got=%0d exp=7", valid_t); end
    n_checks++; if (we_low !== 2) begin n_fail++; $display("FAIL prio_we_low got=%0d exp=2", we_low); end
    n_checks++; if (recov !== 1) begin n_fail++; $display("FAIL prio_recov_cycles got=%0d exp=1", recov); end
    // Read back the word that was just written.
    tick();
    done_t = -1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h8000;
    mem_exp_q.push_back(16'hbeef);
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (mem_done) begin
        done_t = t;
        mem_req = 1'b0;
        exp_v = mem_exp_q.pop_front();
        n_checks++; if (mem_rdata !== exp_v) begin n_fail++; $display("FAIL readback_data got=%h exp=%h", mem_rdata, exp_v); end
        break;
      end
    end
    n_checks++; if (done_t !== 3) begin n_fail++; $display("FAIL readback_cycle got=%0d exp=3", done_t); end
    tick();
    n_checks++; if (mem_done !== 1'b0) begin n_fail++; $display("FAIL readback_single_pulse got=%b exp=0", mem_done); end
  endtask

  task automatic test_mem_drop();
    int pulses, done_t;
    pulses = 0; done_t = -1;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0005;
    mem_exp_q.push_back(pat(16'h0005));
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 1) begin
        mem_req = 1'b0;
        n_checks++; if (dbg_state !== S_MEM_RD) begin n_fail++; $display("FAIL drop_in_read got=%0d exp=%0d", dbg_state, S_MEM_RD); end
      end
      if (mem_done) begin
        pulses++;
        if (pulses == 1) begin
          done_t = t;
          exp_v = mem_exp_q.pop_front();
          n_checks++; if (mem_rdata !== exp_v) begin n_fail++; $display("FAIL drop_data got=%h exp=%h", mem_rdata, exp_v); end
        end
      end
    end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL drop_pulses got=%0d exp=1", pulses); end
    n_checks++; if (done_t !== 3) begin n_fail++; $display("FAIL drop_done_cycle got=%0d exp=3", done_t); end
    n_checks++; if (dbg_state !== S_IDLE) begin n_fail++; $display("FAIL drop_final_state got=%0d exp=%0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_wait_variants();
    int lat0, lat1, lat3, we0, we1, we3, d0, d1, d3;
    lat0 = -1; lat1 = -1; lat3 = -1;
    we0 = 0; we1 = 0; we3 = 0; d0 = 0; d1 = 0; d3 = 0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    if_req = 1'b1; if_addr = 16'h0003;
    for (int k = 0; k < 3; k++) exp_q.push_back(pat(16'h0003));
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (t == 1) if_req = 1'b0;
      if (w0_if_valid && lat0 < 0) begin
        lat0 = t; exp_v = exp_q.pop_front();
        n_checks++; if (w0_if_data !== exp_v) begin n_fail++; $display("FAIL w0_fetch_data got=%h exp=%h", w0_if_data, exp_v); end
      end
      if (if_valid && lat1 < 0) begin
        lat1 = t; exp_v = exp_q.pop_front();
        n_checks++; if (if_data !== exp_v) begin n_fail++; $display("FAIL w1_fetch_data got=%h exp=%h", if_data, exp_v); end
      end
      if (w3_if_valid && lat3 < 0) begin
        lat3 = t; exp_v = exp_q.pop_front();
        n_checks++; if (w3_if_data !== exp_v) begin n_fail++; $display("FAIL w3_fetch_data got=%h exp=%h", w3_if_data, exp_v); end
      end
    end
    n_checks++; if (lat0 !== 2) begin n_fail++; $display("FAIL w0_latency got=%0d exp=2", lat0); end
    n_checks++; if (lat1 !== 3) begin n_fail++; $display("FAIL w1_latency got=%0d exp=3", lat1); end
    n_checks++; if (lat3 !== 5) begin n_fail++; $display("FAIL w3_latency got=%0d exp=5", lat3); end
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0100; mem_wdata = 16'h1234;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 1) begin mem_req = 1'b0; mem_we = 1'b0; end
      if (!w0_we_n) we0++;
      if (!sram_we_n) we1++;
      if (!w3_we_n) we3++;
      if (w0_mem_done) d0++;
      if (mem_done) d1++;
      if (w3_mem_done) d3++;
    end
    n_checks++; if (we0 !== 1) begin n_fail++; $display("FAIL w0_we_low got=%0d exp=1", we0); end
    n_checks++; if (we1 !== 2) begin n_fail++; $display("FAIL w1_we_low got=%0d exp=2", we1); end
    n_checks++; if (we3 !== 4) begin n_fail++; $display("FAIL w3_we_low got=%0d exp=4", we3); end
    n_checks++; if (d0 !== 1 || d1 !== 1 || d3 !== 1) begin n_fail++; $display("FAIL wait_write_done got=%0d/%0d/%0d exp=1/1/1", d0, d1, d3); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_priority();
    test_mem_drop();
    test_wait_variants();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
